day1_stream: RTL

DAY1_STREAM -- requirements
Module: day1_stream

---
 rtl/day1_stream.sv | 134 +++++++++++++
 1 files changed

// File: rtl/day1_stream.sv
// Streaming calorie-counting parser: sums newline-separated numbers into groups
// (groups are separated by blank lines) and reports the largest and the top-three total.
module day1_stream #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic [W-1:0] out1,
  output logic [W-1:0] out2,
  output logic         done
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_num;
  logic [W-1:0] r_gsum;
  logic [W-1:0] r_t1, r_t2, r_t3;
  logic         r_lhd;
  logic         r_open;

  logic         w_acc;
  logic         w_digit;
  logic         w_lf;
  logic [W-1:0] w_pend;
  logic [W-1:0] w_ins_v;
  logic [W-1:0] w_n1, w_n2, w_n3;
  logic [W-1:0] w_f1, w_f2, w_f3;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RUN:   if (w_acc && in_last) w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_RUN;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_RUN) && !rst;
  end

  // Shared top-3 insertion: in RUN it closes the current group, in FLUSH it
  // closes the final group including any number still pending on the last line.
  always_comb begin
    w_acc   = in_valid && in_ready;
    w_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    w_lf    = (in_data == 8'h0A);
    w_pend  = r_gsum + r_num;
    w_ins_v = (r_state == S_FLUSH && r_lhd) ? w_pend : r_gsum;
    w_n1 = r_t1;
    w_n2 = r_t2;
    w_n3 = r_t3;
    if (w_ins_v > r_t1) begin
      w_n1 = w_ins_v;
      w_n2 = r_t1;
      w_n3 = r_t2;
    end else if (w_ins_v > r_t2) begin
      w_n2 = w_ins_v;
      w_n3 = r_t2;
    end else if (w_ins_v > r_t3) begin
      w_n3 = w_ins_v;
    end
    if (r_lhd || r_open) begin
      w_f1 = w_n1;
      w_f2 = w_n2;
      w_f3 = w_n3;
    end else begin
      w_f1 = r_t1;
      w_f2 = r_t2;
      w_f3 = r_t3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num  <= '0;
      r_gsum <= '0;
      r_open <= 1'b0;
      r_lhd  <= 1'b0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_t3   <= '0;
      out1   <= '0;
      out2   <= '0;
      done   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_acc) begin
            if (w_digit) begin
              r_num <= r_num * W'(10) + W'(in_data[3:0]);
              r_lhd <= 1'b1;
            end else if (w_lf) begin
              if (r_lhd) begin
                r_gsum <= w_pend;
                r_num  <= '0;
                r_lhd  <= 1'b0;
                r_open <= 1'b1;
              end else if (r_open) begin
                r_t1   <= w_n1;
                r_t2   <= w_n2;
                r_t3   <= w_n3;
                r_gsum <= '0;
                r_open <= 1'b0;
              end
            end
          end
        end
        S_FLUSH: begin
          r_t1 <= w_f1;
          r_t2 <= w_f2;
          r_t3 <= w_f3;
          out1 <= w_f1;
          out2 <= w_f1 + w_f2 + w_f3;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
